riscv_muldiv: RTL

- Parametrised iterative multiply/divide unit implementing the RV32M/RV64M funct3 operations for the core's execute stage.
- Accepts one operation per start handshake and holds off the pipeline with busy.
- Returns a registered result with a one-cycle done pulse.
- XLEN-generic; optional single-cycle multiplier path selected by parameter.

---
 rtl/riscv_muldiv.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/riscv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// with an optional single-step multiplier. One operation in flight, done pulses for one cycle.
module riscv_muldiv #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Handshake: start is accepted only when busy=0 (IDLE or DONE) and kill=0;
  // done is a single-cycle result-valid strobe and is masked by kill in that same cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        funct_q, funct_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   spec_val_q, spec_val_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic              div_zero, div_ovf, accept;
  logic [XLEN-1:0]   mag_a, mag_b, spec_val;
  logic [2*XLEN-1:0] fast_prod;

  // Operand decode at acceptance. An XLEN-bit unsigned magnitude already holds
  // |most-negative| = 2^(XLEN-1), so no extra magnitude bit is stored.
  always_comb begin
    is_div    = funct[2];
    sgn_a     = !(funct[0] && (funct[1] || funct[2]));
    sgn_b     = sgn_a && (funct != 3'b010);
    a_neg     = sgn_a && rs1[XLEN-1];
    b_neg     = sgn_b && rs2[XLEN-1];
    mag_a     = a_neg ? ('0 - rs1) : rs1;
    mag_b     = b_neg ? ('0 - rs2) : rs2;
    div_zero  = is_div && (rs2 == '0);
    div_ovf   = is_div && !funct[0] && (rs1 == MIN_NEG) && (rs2 == '1);
    spec_val  = div_zero ? (funct[1] ? rs1 : '1) : (funct[1] ? '0 : rs1);
    fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  end

  logic [XLEN:0]     add_sum, shifted, trial;
  logic [2*XLEN-1:0] mul_step, div_step, prod;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step = {add_sum, acc_q[XLEN-1:1]};
    shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    trial    = shifted - {1'b0, opnd_q};
    div_step = trial[XLEN] ? {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                           : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod     = neg_q ? ('0 - acc_q) : acc_q;
    quo_s    = neg_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_s    = neg_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    if (spec_q)                  fix_res = spec_val_q;
    else if (!funct_q[2])        fix_res = (funct_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (funct_q[1])         fix_res = rem_s;
    else                         fix_res = quo_s;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    funct_d    = funct_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;
    accept     = start && !kill && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          acc_d = funct_q[2] ? div_step : mul_step;
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      FIX: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          result_d = fix_res;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Back-to-back issue: DONE accepts a new operation just like IDLE.
    if (accept) begin
      funct_d    = funct;
      cnt_d      = CW'(XLEN - 1);
      spec_d     = div_zero || div_ovf;
      spec_val_d = spec_val;
      neg_d      = (is_div && funct[1]) ? a_neg : (a_neg ^ b_neg);
      opnd_d     = is_div ? mag_b : mag_a;
      acc_d      = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
      if (FAST_MUL && !is_div) acc_d = fast_prod;
      state_d    = (div_zero || div_ovf || (FAST_MUL && !is_div)) ? FIX : CALC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      funct_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      funct_q    <= funct_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      result_q   <= result_d;
    end
  end

  assign busy      = (state_q == CALC) || (state_q == FIX);
  assign done      = (state_q == DONE) && !kill;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
